// File: rtl/spi_master_adc_read_pkg.sv
// Shared definitions for the ADC-read SPI master: FSM state encoding and SPI mode names.
package spi_master_adc_read_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    SS_HOLD  = 3'd3,
    DONE     = 3'd4
  } state_e;

  typedef enum logic {
    CPOL_LOW  = 1'b0,
    CPOL_HIGH = 1'b1
  } cpol_e;

  typedef enum logic {
    CPHA_LEADING  = 1'b0,
    CPHA_TRAILING = 1'b1
  } cpha_e;

endpackage

// File: rtl/spi_master_adc_read_sck_gen.sv
// SPI clock generator: half-period timer plus toggle counter, with edge strobes
// and a strobe on the final (2*WID-th) toggle. Held at the idle level while disabled.
module spi_sck_gen
  import spi_master_adc_read_pkg::*;
#(
  parameter int unsigned WID             = 18,
  parameter int unsigned WID_LEN         = 5,
  parameter int unsigned POLARITY        = 1,
  parameter int unsigned CYCLE_HALF_WAIT = 1,
  parameter int unsigned TIMER_WID       = 8
) (
  input  logic clk,
  input  logic rst_L,
  input  logic enable,
  output logic sck,
  output logic leading_c,
  output logic trailing_c,
  output logic done_c
);

  localparam int unsigned TOG_W = WID_LEN + 1;
  localparam logic SCK_IDLE = (POLARITY == 32'(CPOL_HIGH));
  localparam logic [TIMER_WID-1:0] HALF_LAST = TIMER_WID'(CYCLE_HALF_WAIT - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * WID - 1);

  logic [TIMER_WID-1:0] timer;
  logic [TOG_W-1:0]     toggles;
  logic                 toggle_c;

  // Toggle number is (toggles + 1): even count means an odd (leading) toggle.
  assign toggle_c   = enable && (timer == HALF_LAST);
  assign leading_c  = toggle_c && !toggles[0];
  assign trailing_c = toggle_c && toggles[0];
  assign done_c     = toggle_c && (toggles == TOG_LAST);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      timer   <= '0;
      toggles <= '0;
      sck     <= SCK_IDLE;
    end else if (!enable) begin
      timer   <= '0;
      toggles <= '0;
      sck     <= SCK_IDLE;
    end else if (toggle_c) begin
      timer   <= '0;
      toggles <= toggles + TOG_W'(1);
      sck     <= ~sck;
    end else begin
      timer   <= timer + TIMER_WID'(1);
    end
  end

endmodule

// File: rtl/spi_master_adc_read.sv
// SPI master reading one WID-bit ADC word per arm/finished handshake.
// Optional SPI_MISO_SYNC_EN inserts a 2-flop miso synchronizer (needs CYCLE_HALF_WAIT >= 3).
module spi_master_adc_read
  import spi_master_adc_read_pkg::*;
#(
  parameter int unsigned WID             = 18,
  parameter int unsigned WID_LEN         = 5,
  parameter int unsigned POLARITY        = 1,
  parameter int unsigned PHASE           = 0,
  parameter int unsigned CYCLE_HALF_WAIT = 1,
  parameter int unsigned TIMER_WID       = 8,
  parameter int unsigned SS_WAIT         = 2
) (
  input  logic           clk,
  input  logic           rst_L,
  input  logic           arm,
  output logic           ready_to_arm,
  output logic           finished,
  output logic [WID-1:0] from_slave,
  output logic           sck,
  output logic           ss_L,
  input  logic           miso
);

  localparam logic [TIMER_WID-1:0] SS_LAST  = TIMER_WID'(SS_WAIT - 1);
  localparam logic [WID_LEN-1:0]   BITS_ALL = WID_LEN'(WID);

  state_e               state, state_nxt;
  logic [TIMER_WID-1:0] wait_cnt, wait_cnt_nxt;
  logic [WID_LEN-1:0]   bit_cnt, bit_cnt_nxt;
  logic [WID-1:0]       shreg, shreg_nxt, from_slave_nxt;
  logic                 ss_L_nxt, finished_nxt, ready_nxt;
  logic                 sck_en_c, lead_c, trail_c, sck_done_c, sample_c, miso_s;

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) miso_sync <= '0;
    else        miso_sync <= {miso_sync[0], miso};
  end

  assign miso_s = miso_sync[1];

  always_ff @(posedge clk) begin
    if (rst_L) assert (CYCLE_HALF_WAIT >= 3)
      else $error("spi_master_adc_read: CYCLE_HALF_WAIT must be >= 3 with miso sync");
  end
`else
  assign miso_s = miso;
`endif

  // Dropping arm stops sck on the same edge that the FSM aborts.
  assign sck_en_c = (state == SHIFT) && arm;
  assign sample_c = (PHASE == 32'(CPHA_TRAILING)) ? trail_c : lead_c;

  spi_sck_gen #(
    .WID            (WID),
    .WID_LEN        (WID_LEN),
    .POLARITY       (POLARITY),
    .CYCLE_HALF_WAIT(CYCLE_HALF_WAIT),
    .TIMER_WID      (TIMER_WID)
  ) u_sck_gen (
    .clk       (clk),
    .rst_L     (rst_L),
    .enable    (sck_en_c),
    .sck       (sck),
    .leading_c (lead_c),
    .trailing_c(trail_c),
    .done_c    (sck_done_c)
  );

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    from_slave_nxt = from_slave;
    ss_L_nxt       = ss_L;
    finished_nxt   = finished;
    ready_nxt      = ready_to_arm;

    if (sample_c) begin
      shreg_nxt   = {shreg[WID-2:0], miso_s};
      bit_cnt_nxt = bit_cnt + WID_LEN'(1);
    end

    case (state)
      IDLE: begin
        ss_L_nxt     = 1'b1;
        finished_nxt = 1'b0;
        ready_nxt    = 1'b1;
        if (arm) begin
          state_nxt    = SS_SETUP;
          ss_L_nxt     = 1'b0;
          ready_nxt    = 1'b0;
          wait_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
        end
      end
      SS_SETUP, SHIFT, SS_HOLD: begin
        if (!arm) begin
          // Abort: deselect and return; from_slave keeps the last published word.
          state_nxt = IDLE;
          ss_L_nxt  = 1'b1;
          ready_nxt = 1'b1;
        end else if (state == SS_SETUP) begin
          if (wait_cnt == SS_LAST) begin
            state_nxt    = SHIFT;
            wait_cnt_nxt = '0;
          end else begin
            wait_cnt_nxt = wait_cnt + TIMER_WID'(1);
          end
        end else if (state == SHIFT) begin
          if (sck_done_c && (bit_cnt_nxt == BITS_ALL)) begin
            state_nxt    = SS_HOLD;
            wait_cnt_nxt = '0;
          end
        end else begin
          if (wait_cnt == SS_LAST) begin
            state_nxt      = DONE;
            ss_L_nxt       = 1'b1;
            finished_nxt   = 1'b1;
            from_slave_nxt = shreg;
          end else begin
            wait_cnt_nxt = wait_cnt + TIMER_WID'(1);
          end
        end
      end
      DONE: begin
        if (!arm) begin
          state_nxt    = IDLE;
          finished_nxt = 1'b0;
          ready_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      from_slave   <= '0;
      ss_L         <= 1'b1;
      finished     <= 1'b0;
      ready_to_arm <= 1'b1;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shreg        <= shreg_nxt;
      from_slave   <= from_slave_nxt;
      ss_L         <= ss_L_nxt;
      finished     <= finished_nxt;
      ready_to_arm <= ready_nxt;
    end
  end

endmodule

// File: doc/spi_master_adc_read.md
Name: spi_master_adc_read

Overview:
- SPI master that reads one WID-bit word per armed transaction from an ADC, or from the ADC simulator in loopback benches.
- Drives sck and ss_L, samples miso MSB-first and presents the word through a level arm/finished handshake.
- Sits between the control loop's sample scheduler and the ADC SPI pins.

Parameters:
WID, 18, data word width in bits
WID_LEN, 5, width of the bit counter; must satisfy 2**WID_LEN > WID
POLARITY, 1, sck idle level (CPOL)
PHASE, 0, 0 = sample on leading sck edge; 1 = sample on trailing sck edge (CPHA)
CYCLE_HALF_WAIT, 1, clk cycles per sck half-period; minimum 1 (minimum 3 when SPI_MISO_SYNC_EN is defined)
TIMER_WID, 8, width of the half-period and setup/hold timers
SS_WAIT, 2, clk cycles from ss_L fall to first sck edge, and from last sck edge to ss_L rise; minimum 1

Ports:
clk  in  1  system clock
rst_L  in  1  asynchronous active-low reset
arm  in  1  level request; rising into IDLE starts a transaction
ready_to_arm  out  1  high in IDLE only
finished  out  1  high in DONE; from_slave is valid
from_slave  out  WID  last completed word
sck  out  1  SPI clock
ss_L  out  1  active-low slave select
miso  in  1  serial data from slave

Behaviour:
- Reset values (async, rst_L=0): state IDLE, sck=POLARITY, ss_L=1, finished=0, ready_to_arm=1, from_slave=0, all counters 0.
- States: IDLE, SS_SETUP, SHIFT, SS_HOLD, DONE.
- IDLE: sck=POLARITY, ss_L=1. When arm=1 at a clk edge: ss_L=0 and ready_to_arm=0 at that edge; enter SS_SETUP.
- SS_SETUP: counts SS_WAIT cycles, then enters SHIFT. The first sck toggle occurs CYCLE_HALF_WAIT cycles after entering SHIFT.
- SHIFT:
  - sck toggles every CYCLE_HALF_WAIT cycles, for exactly 2*WID toggles; sck ends at POLARITY.
  - PHASE=0: sample miso on toggles 1,3,5,…
  - PHASE=1: sample miso on toggles 2,4,6,…
  - Each sample shifts into a WID-bit shift register, MSB received first.
  - The bit counter (WID_LEN bits) counts samples; SHIFT exits after WID samples and 2*WID toggles.
- SS_HOLD: counts SS_WAIT cycles, then ss_L=1, from_slave<=shift register, finished=1; enter DONE.
  - Total latency from arm to finished: 1 + SS_WAIT + 2*WID*CYCLE_HALF_WAIT + SS_WAIT clk cycles.
- DONE: holds finished=1 and from_slave stable while arm=1. When arm=0: finished=0, ready_to_arm=1, return to IDLE next cycle.
  - A new transaction needs arm low for at least one cycle.
- Abort: arm=0 in SS_SETUP, SHIFT or SS_HOLD. Next edge: ss_L=1, sck=POLARITY, IDLE. from_slave keeps its prior value; finished never pulses.
- Simultaneous arm fall and transition into DONE: abort wins. finished stays 0, from_slave is not updated.
- Reset mid-transaction: immediate reset values; no partial word is published.
- ss_L and sck are registered outputs with no combinational glitches.

Optional Feature:
- Macro: SPI_MISO_SYNC_EN.
- Defined:
  - miso passes through a 2-flop synchronizer before sampling. The sample is taken from the synchronized value at the sampling toggle, i.e. miso as it was 2 clk cycles earlier.
  - CYCLE_HALF_WAIT >= 3 is required; a simulation-time check flags violations.
- Undefined: miso is sampled directly at the toggle edge. Zero added latency.

Decomposition:
- Shared control-loop package/include holds:
  - state encoding localparams: IDLE=0, SS_SETUP=1, SHIFT=2, SS_HOLD=3, DONE=4
  - SPI mode constants: CPOL/CPHA names
- One sub-module, spi_sck_gen: half-period timer plus toggle counter.
  - Inputs: enable.
  - Outputs: sck, leading/trailing edge strobes, done after 2*WID toggles.
- The FSM, shift register and handshake stay in spi_master_adc_read.

Test Plan:
- Mode (POLARITY=1, PHASE=0), loopback to adc_sim with the same parameters, indat=18'h2A5A5; arm held -> finished=1, from_slave=18'h2A5A5. finished cycle matches the latency formula; ss_L=1 at finished.
- All four POLARITY/PHASE combinations, indat=18'h20001 and 18'h1FFFE -> words match exactly; sck idles at POLARITY before and after each transaction.
- Abort: drop arm after 7 sck toggles (previous word 18'h12345) -> ss_L=1 and sck=POLARITY next cycle; finished stays 0; from_slave stays 18'h12345; a re-arm then completes normally.
- Handshake: keep arm high 50 cycles past finished -> from_slave stable, no second transaction; arm low -> ready_to_arm=1 after 1 cycle.
- rst_L pulsed low mid-SHIFT -> all outputs take reset values asynchronously (from_slave=0); the next transaction reads correctly.
- SPI_MISO_SYNC_EN defined, CYCLE_HALF_WAIT=3, indat=18'h3C3C3 -> from_slave=18'h3C3C3; same test with CYCLE_HALF_WAIT=2 -> check fires.
